// File: rtl/bf16_add_scheduler.sv
// rtl/bf16_add_scheduler.sv - round-robin scheduler sharing one three-phase bfloat16_adder
// Optional macro BF16_ADD_SCHED_WATCHDOG_EN adds rsp_err and a timeout out of WAIT.

module bf16_add_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [16*NUM_REQ-1:0] req_a,
  input  logic [16*NUM_REQ-1:0] req_b,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [15:0]           rsp_sum,
  output logic [ID_W-1:0]       rsp_id,
  output logic [15:0]           add_a,
  output logic [15:0]           add_b,
  input  logic [15:0]           add_sum,
  input  logic                  add_ready,
`ifdef BF16_ADD_SCHED_WATCHDOG_EN
  output logic                  rsp_err,
`endif
  output logic                  busy
);

  typedef enum logic [2:0] {IDLE, PH_A, PH_B, WAIT, RESP} state_t;

  state_t          state;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] win_idx;
  logic [ID_W-1:0] cand;
  logic            win_found;
  logic            grant;
  logic [15:0]     op_a;
  logic [15:0]     op_b;

`ifdef BF16_ADD_SCHED_WATCHDOG_EN
  localparam logic [3:0] WD_LAST = 4'd7;
  logic [3:0] wd_cnt;
`endif

  // Search upward from the slot after the last winner so it ends up lowest priority.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Grants only line up with the adder's phase-3 boundary.
  assign grant = (state == IDLE) && add_ready && win_found && !reset;

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = grant && (win_idx == ID_W'(i));
    end
  end

  assign add_a = op_a;
  assign add_b = op_b;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      rr_ptr    <= ID_W'(NUM_REQ - 1);
      op_a      <= '0;
      op_b      <= '0;
      rsp_valid <= 1'b0;
      rsp_sum   <= '0;
      rsp_id    <= '0;
      busy      <= 1'b0;
`ifdef BF16_ADD_SCHED_WATCHDOG_EN
      rsp_err   <= 1'b0;
      wd_cnt    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (grant) begin
            op_a   <= req_a[16*win_idx +: 16];
            op_b   <= req_b[16*win_idx +: 16];
            rr_ptr <= win_idx;
            rsp_id <= win_idx;
            busy   <= 1'b1;
            state  <= PH_A;
`ifdef BF16_ADD_SCHED_WATCHDOG_EN
            wd_cnt <= '0;
`endif
          end
        end
        PH_A: begin
          state <= PH_B;
`ifdef BF16_ADD_SCHED_WATCHDOG_EN
          wd_cnt <= wd_cnt + 4'd1;
`endif
        end
        PH_B: begin
          state <= WAIT;
`ifdef BF16_ADD_SCHED_WATCHDOG_EN
          wd_cnt <= wd_cnt + 4'd1;
`endif
        end
        WAIT: begin
`ifdef BF16_ADD_SCHED_WATCHDOG_EN
          wd_cnt <= wd_cnt + 4'd1;
`endif
          if (add_ready) begin
            rsp_sum   <= add_sum;
            rsp_valid <= 1'b1;
            state     <= RESP;
`ifdef BF16_ADD_SCHED_WATCHDOG_EN
            rsp_err   <= 1'b0;
          end else if (wd_cnt == WD_LAST) begin
            // Adder never reached phase 3: answer with canonical NaN and flag it.
            rsp_sum   <= 16'h7FC0;
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
            state     <= RESP;
`endif
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bf16_add_scheduler.sv
// tb/tb_bf16_add_scheduler.sv - directed bench for bf16_add_scheduler with a three-phase adder model
// Define BF16_ADD_SCHED_WATCHDOG_EN for both files to exercise the timeout path.

module tb_bf16_add_scheduler;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  logic                  clock;
  logic                  reset;
  logic [NUM_REQ-1:0]    req_valid;
  logic [16*NUM_REQ-1:0] req_a;
  logic [16*NUM_REQ-1:0] req_b;
  logic [NUM_REQ-1:0]    req_ready;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [15:0]           rsp_sum;
  logic [ID_W-1:0]       rsp_id;
  logic [15:0]           add_a;
  logic [15:0]           add_b;
  logic [15:0]           add_sum;
  logic                  add_ready;
  logic                  busy;
`ifdef BF16_ADD_SCHED_WATCHDOG_EN
  logic                  rsp_err;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  bf16_add_scheduler #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_sum(rsp_sum), .rsp_id(rsp_id),
    .add_a(add_a), .add_b(add_b), .add_sum(add_sum), .add_ready(add_ready),
`ifdef BF16_ADD_SCHED_WATCHDOG_EN
    .rsp_err(rsp_err),
`endif
    .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Adder model: latches a in phase 0, b in phase 1, presents the sum with ready in phase 2.
  logic [1:0]  phase;
  logic [15:0] la, lb;
  logic        force_low;

  function automatic logic [15:0] model_sum(input logic [15:0] a, input logic [15:0] b);
    case ({a, b})
      {16'h3F80, 16'h4000}: return 16'h4040;
      {16'h3F80, 16'h3F80}: return 16'h4000;
      {16'h3F80, 16'hBF80}: return 16'h0000;
      {16'h4000, 16'h4000}: return 16'h4080;
      default:              return 16'hFFFF;
    endcase
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      phase <= 2'd0;
      la    <= 16'h0;
      lb    <= 16'h0;
    end else begin
      phase <= (phase == 2'd2) ? 2'd0 : phase + 2'd1;
      if (phase == 2'd0) la <= add_a;
      if (phase == 2'd1) lb <= add_b;
    end
  end

  assign add_ready = (phase == 2'd2) && !force_low;
  assign add_sum   = (phase == 2'd2) ? model_sum(la, lb) : 16'h0;

  task automatic wait_grant(input int bound, output int idx, output bit ok);
    ok  = 1'b0;
    idx = -1;
    for (int c = 0; c < bound && !ok; c++) begin
      #1;
      if (req_ready != '0) begin
        ok = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) if (req_ready[i]) idx = i;
      end else begin
        @(negedge clock);
      end
    end
  endtask

  task automatic wait_rsp(input int bound, output int k, output bit ok);
    k  = 0;
    ok = 1'b0;
    while (k < bound && !ok) begin
      @(negedge clock);
      k++;
      if (rsp_valid) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req_valid = '1;
    #10;
    n_cmp++; if (req_ready !== '0)   begin n_bad++; $display("FAIL reset_req_ready: got %b want 0", req_ready); end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    n_cmp++; if (rsp_sum !== 16'h0)  begin n_bad++; $display("FAIL reset_rsp_sum: got %h want 0000", rsp_sum); end
    n_cmp++; if (rsp_id !== '0)      begin n_bad++; $display("FAIL reset_rsp_id: got %0d want 0", rsp_id); end
    n_cmp++; if (add_a !== 16'h0 || add_b !== 16'h0) begin n_bad++; $display("FAIL reset_operands: got %h/%h want 0000/0000", add_a, add_b); end
    n_cmp++; if (busy !== 1'b0)      begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    @(negedge clock);
    req_valid = '0;
    reset = 1'b0;
  endtask

  task automatic test_single(input string name, input int idx, input logic [15:0] a,
                             input logic [15:0] b, input logic [15:0] exp_sum);
    int g; int k; bit ok;
    req_a[16*idx +: 16] = a;
    req_b[16*idx +: 16] = b;
    rsp_ready = 1'b1;
    req_valid = '0;
    req_valid[idx] = 1'b1;
    wait_grant(10, g, ok);
    n_cmp++; if (!ok || g != idx) begin n_bad++; $display("FAIL %s_grant: got %0d want %0d", name, g, idx); end
    n_cmp++; if (add_ready !== 1'b1) begin n_bad++; $display("FAIL %s_grant_phase: add_ready %b want 1", name, add_ready); end
    @(negedge clock);
    n_cmp++; if (req_ready !== '0) begin n_bad++; $display("FAIL %s_pulse: req_ready %b want 0", name, req_ready); end
    n_cmp++; if (add_a !== a || add_b !== b) begin n_bad++; $display("FAIL %s_operands: got %h/%h want %h/%h", name, add_a, add_b, a, b); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL %s_busy: got %b want 1", name, busy); end
    wait_rsp(10, k, ok);
    // k counts negedges from the one after the grant edge, so k==3 means three edges after the grant.
    n_cmp++; if (!ok || k != 3) begin n_bad++; $display("FAIL %s_latency: got %0d want 3", name, k); end
    n_cmp++; if (rsp_sum !== exp_sum) begin n_bad++; $display("FAIL %s_sum: got %h want %h", name, rsp_sum, exp_sum); end
    n_cmp++; if (rsp_id !== ID_W'(idx)) begin n_bad++; $display("FAIL %s_id: got %0d want %0d", name, rsp_id, idx); end
`ifdef BF16_ADD_SCHED_WATCHDOG_EN
    n_cmp++; if (rsp_err !== 1'b0) begin n_bad++; $display("FAIL %s_err: got %b want 0", name, rsp_err); end
`endif
    req_valid = '0;
    @(negedge clock);
    n_cmp++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL %s_done: rsp_valid %b busy %b want 0 0", name, rsp_valid, busy); end
  endtask

  task automatic test_contention();
    logic [15:0] exp_sum [NUM_REQ];
    int g; int k; bit ok;
    exp_sum[0] = 16'h4040; exp_sum[1] = 16'h4000; exp_sum[2] = 16'h0000; exp_sum[3] = 16'h4080;
    req_a = {16'h4000, 16'h3F80, 16'h3F80, 16'h3F80};
    req_b = {16'h4000, 16'hBF80, 16'h3F80, 16'h4000};
    rsp_ready = 1'b1;
    req_valid = 4'b1111;
    for (int op = 0; op < NUM_REQ; op++) begin
      wait_grant(10, g, ok);
      n_cmp++; if (!ok || g != op) begin n_bad++; $display("FAIL rr_grant%0d: got %0d want %0d", op, g, op); end
      n_cmp++; if (!$onehot(req_ready)) begin n_bad++; $display("FAIL rr_onehot%0d: got %b want one-hot", op, req_ready); end
      @(negedge clock);
      n_cmp++; if (req_ready !== '0) begin n_bad++; $display("FAIL rr_pulse%0d: got %b want 0", op, req_ready); end
      wait_rsp(10, k, ok);
      n_cmp++; if (!ok || rsp_id !== ID_W'(op)) begin n_bad++; $display("FAIL rr_id%0d: got %0d want %0d", op, rsp_id, op); end
      n_cmp++; if (rsp_sum !== exp_sum[op]) begin n_bad++; $display("FAIL rr_sum%0d: got %h want %h", op, rsp_sum, exp_sum[op]); end
    end
    req_valid = 4'b0001;
    wait_grant(10, g, ok);
    n_cmp++; if (!ok || g != 0) begin n_bad++; $display("FAIL rr_regrant: got %0d want 0", g); end
    @(negedge clock);
    wait_rsp(10, k, ok);
    n_cmp++; if (!ok || rsp_id !== '0 || rsp_sum !== 16'h4040) begin n_bad++; $display("FAIL rr_regrant_rsp: got id %0d sum %h want 0 4040", rsp_id, rsp_sum); end
    req_valid = '0;
    @(negedge clock);
  endtask

  task automatic test_backpressure();
    int g; int k; bit ok; int hs;
    rsp_ready = 1'b0;
    req_valid = 4'b1000;
    wait_grant(10, g, ok);
    n_cmp++; if (!ok || g != 3) begin n_bad++; $display("FAIL bp_grant: got %0d want 3", g); end
    @(negedge clock);
    req_valid = 4'b1001;
    wait_rsp(10, k, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL bp_rsp: rsp_valid %b want 1", rsp_valid); end
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      n_cmp++;
      if (rsp_valid !== 1'b1 || rsp_sum !== 16'h4080 || rsp_id !== 2'd3 || busy !== 1'b1 || req_ready !== '0) begin
        n_bad++;
        $display("FAIL bp_hold%0d: valid %b sum %h id %0d busy %b req_ready %b want 1 4080 3 1 0000",
                 c, rsp_valid, rsp_sum, rsp_id, busy, req_ready);
      end
    end
    rsp_ready = 1'b1;
    req_valid = 4'b0001;
    hs = 0;
    @(posedge clock);
    if (rsp_valid && rsp_ready) hs++;
    @(negedge clock);
    n_cmp++; if (hs != 1 || rsp_valid !== 1'b0) begin n_bad++; $display("FAIL bp_handshake: count %0d rsp_valid %b want 1 0", hs, rsp_valid); end
    wait_grant(10, g, ok);
    n_cmp++; if (!ok || g != 0 || add_ready !== 1'b1) begin n_bad++; $display("FAIL bp_next_grant: got %0d ready %b want 0 1", g, add_ready); end
    @(negedge clock);
    wait_rsp(10, k, ok);
    n_cmp++; if (!ok || rsp_sum !== 16'h4040 || rsp_id !== '0) begin n_bad++; $display("FAIL bp_next_rsp: got %h id %0d want 4040 0", rsp_sum, rsp_id); end
    req_valid = '0;
    @(negedge clock);
  endtask

  task automatic test_reset_midop();
    int g; int k; bit ok; bit seen;
    rsp_ready = 1'b1;
    req_valid = 4'b0010;
    wait_grant(10, g, ok);
    n_cmp++; if (!ok || g != 1) begin n_bad++; $display("FAIL mid_grant: got %0d want 1", g); end
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    n_cmp++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || rsp_id !== '0 || rsp_sum !== 16'h0 ||
        add_a !== 16'h0 || add_b !== 16'h0 || req_ready !== '0) begin
      n_bad++;
      $display("FAIL mid_reset_outputs: valid %b busy %b id %0d sum %h a %h b %h rr %b want all 0",
               rsp_valid, busy, rsp_id, rsp_sum, add_a, add_b, req_ready);
    end
    reset = 1'b0;
    req_valid = '0;
    seen = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clock);
      if (rsp_valid) seen = 1'b1;
    end
    n_cmp++; if (seen) begin n_bad++; $display("FAIL mid_no_rsp: rsp_valid seen 1 want 0"); end
    req_valid = 4'b1111;
    wait_grant(10, g, ok);
    n_cmp++; if (!ok || g != 0) begin n_bad++; $display("FAIL mid_rr_reset: got %0d want 0", g); end
    @(negedge clock);
    wait_rsp(10, k, ok);
    req_valid = '0;
    @(negedge clock);
  endtask

`ifdef BF16_ADD_SCHED_WATCHDOG_EN
  task automatic test_watchdog();
    int g; int k; bit ok;
    rsp_ready = 1'b1;
    req_a[15:0] = 16'h3F80;
    req_b[15:0] = 16'h4000;
    req_valid = 4'b0001;
    wait_grant(10, g, ok);
    n_cmp++; if (!ok || g != 0) begin n_bad++; $display("FAIL wd_grant: got %0d want 0", g); end
    @(negedge clock);
    force_low = 1'b1;
    wait_rsp(12, k, ok);
    n_cmp++; if (!ok || k > 8) begin n_bad++; $display("FAIL wd_latency: got %0d want <=8", k); end
    n_cmp++; if (rsp_err !== 1'b1 || rsp_sum !== 16'h7FC0) begin n_bad++; $display("FAIL wd_result: err %b sum %h want 1 7FC0", rsp_err, rsp_sum); end
    req_valid = '0;
    @(negedge clock);
    force_low = 1'b0;
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL wd_done: rsp_valid %b want 0", rsp_valid); end
  endtask
`endif

  initial begin
    reset = 1'b0;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    rsp_ready = 1'b0;
    force_low = 1'b0;
    #2;
    test_reset();
    test_single("basic", 0, 16'h3F80, 16'h4000, 16'h4040);
    test_single("double", 1, 16'h3F80, 16'h3F80, 16'h4000);
    test_single("cancel", 3, 16'h3F80, 16'hBF80, 16'h0000);
    test_contention();
    test_backpressure();
    test_reset_midop();
`ifdef BF16_ADD_SCHED_WATCHDOG_EN
    test_watchdog();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at 200000 want finished");
    $fatal(1);
  end

endmodule

// File: doc/bf16_add_scheduler.md
Name: bf16_add_scheduler

Overview:
- Shares one bfloat16_adder instance between NUM_REQ requesters using round-robin arbitration.
- Sequences the adder's free-running three-phase cycle: operand A is latched in phase 1, operand B in phase 2, and the sum is valid in phase 3 while the adder drives `ready`.
- Returns each sum, tagged with the requester index, on a single valid/ready response channel.
- Sits between compute clients and the adder. The top level ties the adder's `nreset` to `~reset`.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, $clog2(NUM_REQ), width of the requester index.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester operation request.
- req_a  in  16*NUM_REQ  operand A; requester i uses bits [16i+15:16i].
- req_b  in  16*NUM_REQ  operand B, packed the same way as req_a.
- req_ready  out  NUM_REQ  one-hot grant; a request is accepted when req_valid[i] & req_ready[i].
- rsp_valid  out  1  response holds a valid result.
- rsp_ready  in  1  consumer accepts the response.
- rsp_sum  out  16  bfloat16 result.
- rsp_id  out  ID_W  index of the requester that issued the operation.
- add_a  out  16  to adder input a.
- add_b  out  16  to adder input b.
- add_sum  in  16  from adder output sum.
- add_ready  in  1  from adder output ready.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values: all outputs 0, state=IDLE, rr_ptr=NUM_REQ-1 (requester 0 has first priority), operand registers 0.
- FSM states: IDLE, PH_A, PH_B, WAIT, RESP.
- IDLE -> PH_A:
  - Condition: add_ready=1 and at least one req_valid bit is set.
  - Winner: the first set req_valid bit searching upward from rr_ptr+1, with modulo wrap.
  - In that same cycle: req_ready[winner]=1 (combinational), op_a/op_b are registered from the winner's slice, rr_ptr and the ID are updated.
- IDLE with add_ready=0: no grant is made, so every request waits for the adder's phase-3 boundary.
- PH_A -> PH_B -> WAIT: one cycle each. add_a=op_a and add_b=op_b are driven from registers and held stable from the grant edge until the transaction leaves WAIT.
- WAIT -> RESP:
  - Condition: add_ready=1.
  - Action: capture add_sum into rsp_sum, set rsp_valid=1.
  - Latency: rsp_valid rises exactly 3 clock edges after the grant edge.
- RESP:
  - rsp_sum and rsp_id stay stable while rsp_valid=1 and rsp_ready=0.
  - When rsp_valid & rsp_ready, go to IDLE with rsp_valid=0.
  - The next grant waits for the following add_ready cycle.
- req_ready is 0 in every state except the IDLE grant cycle. At most one bit of req_ready is ever set.
- A requester that deasserts req_valid before it is granted is simply skipped; there is no penalty.
- Simultaneous requests: round-robin. A requester that was just served gets lowest priority on the next arbitration.
- Reset asserted mid-operation: the in-flight operation is dropped, no response is produced, and all state returns to reset values.
- The scheduler does no arithmetic. Special cases (zero, inf/NaN, large exponent difference) are resolved entirely by the adder.

Optional Feature:
- Macro: BF16_ADD_SCHED_WATCHDOG_EN
- With the macro defined:
  - An extra output port rsp_err (1 bit) is added.
  - A 4-bit counter runs in PH_A, PH_B and WAIT.
  - If add_ready is not seen in WAIT within 8 cycles of the grant, go to RESP with rsp_sum=16'h7FC0 (canonical NaN) and rsp_err=1.
  - rsp_err=0 on normal completion; reset value 0.
- Without the macro: no rsp_err port and no counter. WAIT waits indefinitely.

Test Plan:
- Reset, then single request: req_valid=0001, req_a0=16'h3F80, req_b0=16'h4000 -> granted on the first add_ready cycle; 3 edges later rsp_valid=1, rsp_sum=16'h4040, rsp_id=0.
- Doubling: req_a1=req_b1=16'h3F80 -> rsp_sum=16'h4000, rsp_id=1.
- Zero cancellation: a=16'h3F80, b=16'hBF80 -> rsp_sum=16'h0000.
- Contention: req_valid=1111 held for 4 operations with rsp_ready=1 -> rsp_id sequence 0,1,2,3. Then only requester 0 requests -> rsp_id=0 again. Each req_ready is a one-hot single-cycle pulse.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid -> rsp_sum and rsp_id are held, busy=1, no new req_ready. Release -> exactly one handshake, then the next grant at the next add_ready.
- Reset pulsed in PH_B -> all outputs 0 the next cycle, no response ever appears. With BF16_ADD_SCHED_WATCHDOG_EN defined and add_ready forced to 0 after the grant -> rsp_valid=1, rsp_err=1, rsp_sum=16'h7FC0 within 8 cycles.
